cmd_sched: RTL and testbench
============================

Name: cmd_sched

Overview:
- Command scheduler that drains the AXI-fed command FIFO through its vld/rdy pop port.
- Decodes each 32-bit command word and issues LOAD/COMPUTE/STORE operations to the downstream engine over a req/ack handshake.
- Tracks in-flight operations until the engine reports completion, and implements SYNC barriers.
- Reports busy, an error code, and a retired-command count to the CSR block.

Parameters:
- WDATA_WIDTH, 32, command word width; must be 32.
- MAX_OUTSTD, 4, maximum in-flight engine operations (1..15).
- CNT_WIDTH, 16, width of the retired-command counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_buff_ctrl_out_vld  in  1  command FIFO has a head entry.
- cmd_buff_ctrl_out_data  in  WDATA_WIDTH  command FIFO head word.
- ctrl_cmd_buff_rdy  out  1  pop strobe; the head entry is consumed when vld&rdy.
- eng_req  out  1  engine operation request.
- eng_op  out  2  operation: 1=LOAD, 2=COMPUTE, 3=STORE.
- eng_addr  out  16  command word [15:0].
- eng_len  out  12  command word [27:16].
- eng_ack  in  1  engine accepts the request this cycle.
- eng_done  in  1  one-cycle pulse: one in-flight operation has completed.
- err_clr  in  1  one-cycle pulse: clear error and resume.
- busy  out  1  high when state!=IDLE or outstanding!=0.
- cmd_err  out  2  0=none, 1=illegal opcode, 2=zero-length LOAD/STORE, 3=spurious done.
- cmd_cnt  out  CNT_WIDTH  retired-command count; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Command format: [31:28] opcode, [27:16] len, [15:0] addr.
- Opcodes: 0=NOP, 1=LOAD, 2=COMPUTE, 3=STORE, 4=SYNC; 5..15 are illegal.
- Reset values: state IDLE, cmd register 0, outstanding 0, and all outputs 0 (ctrl_cmd_buff_rdy=0, eng_req=0, eng_op/eng_addr/eng_len=0, busy=0, cmd_err=0, cmd_cnt=0).
- States: IDLE, DECODE, ISSUE, SYNC_WAIT, ERR.
- IDLE:
  - ctrl_cmd_buff_rdy=1 combinationally whenever state==IDLE; it is 0 in every other state.
  - On vld&rdy, capture the word into the command register and go to DECODE. At most one pop per command.
- DECODE (1 cycle), on the registered word:
  - NOP: cmd_cnt+1, go to IDLE.
  - LOAD/STORE with len==0: cmd_err=2, go to ERR.
  - LOAD/COMPUTE/STORE otherwise: go to ISSUE (COMPUTE allows len 0).
  - SYNC: go to SYNC_WAIT.
  - Illegal opcode: cmd_err=1, go to ERR.
- ISSUE:
  - eng_req=1 only while outstanding<MAX_OUTSTD; otherwise eng_req=0 (stall).
  - eng_op/addr/len are driven from the command register and held stable while eng_req=1.
  - On eng_req&eng_ack: outstanding+1, cmd_cnt+1, go to IDLE.
  - The engine must not see eng_req drop before ack, except via reset.
- Latency: a pop at edge N gives DECODE in cycle N+1 and eng_req at the earliest in cycle N+2.
- SYNC_WAIT: when outstanding==0, including a done in the same cycle that brings it to 0: cmd_cnt+1, go to IDLE.
- Outstanding counter, evaluated in every state:
  - Increments on ack and decrements on eng_done.
  - Simultaneous ack and done: net unchanged.
  - eng_done while outstanding==0 and no same-cycle ack: counter stays 0, cmd_err=3, and the FSM is forced to ERR from any state.
  - Exception: an ISSUE handshake in that same cycle completes first (counter ends at 1, cmd_cnt+1), and ERR is entered next cycle.
- Error precedence: the first error wins; cmd_err is not overwritten while non-zero.
- ERR:
  - rdy=0 and eng_req=0; outstanding still decrements on done.
  - err_clr: cmd_err=0, go to IDLE. err_clr outside ERR is ignored.
- Boundaries:
  - Empty FIFO: wait in IDLE indefinitely.
  - cmd_cnt wraps from all-ones to 0.
  - Reset mid-operation drops any pending request immediately and discards the in-flight count.

Test Plan:
- Push 0x1004_0100 (LOAD len=4 addr=0x100) with eng_ack 2 cycles after req -> rdy pulse on the pop; eng_req, eng_op=1, eng_len=4, eng_addr=0x0100 held for 2 cycles; outstanding=1, cmd_cnt=1, busy stays 1 until eng_done.
- Push 5 COMPUTE commands, ack immediately, no eng_done -> 4 issued, 5th held in ISSUE with eng_req=0 and FIFO not popped further; one eng_done -> 5th issued next cycle.
- LOAD, STORE, SYNC, NOP with done after 10 cycles each -> SYNC stays in SYNC_WAIT until the 2nd done, the NOP is popped only afterwards, final cmd_cnt=4.
- Push 0x7000_0000 -> cmd_err=1, rdy=0 while a following LOAD sits unpopped; err_clr -> LOAD then proceeds normally.
- Push 0x3000_0010 (STORE len=0) -> cmd_err=2. Separately, eng_done pulse while idle -> cmd_err=3; same-cycle ack+done with outstanding=1 -> outstanding stays 1.
- Assert rst_n=0 while eng_req=1 -> eng_req, busy, cmd_cnt, cmd_err and rdy all 0 asynchronously; the first pop after release behaves as from reset.

Source files
------------

// File: rtl/cmd_sched.sv
// ============================================================================
// Module : cmd_sched
// Brief  : Pops command words, decodes them and issues LOAD/COMPUTE/STORE to
//          the engine with outstanding tracking, SYNC barriers and error codes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmd_sched #(
    parameter int WDATA_WIDTH = 32,
    parameter int MAX_OUTSTD  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_buff_ctrl_out_vld,
    input  logic [WDATA_WIDTH-1:0] cmd_buff_ctrl_out_data,
    output logic                   ctrl_cmd_buff_rdy,
    output logic                   eng_req,
    output logic [1:0]             eng_op,
    output logic [15:0]            eng_addr,
    output logic [11:0]            eng_len,
    input  logic                   eng_ack,
    input  logic                   eng_done,
    input  logic                   err_clr,
    output logic                   busy,
    output logic [1:0]             cmd_err,
    output logic [CNT_WIDTH-1:0]   cmd_cnt
);

    localparam int                     c_OUT_WIDTH = $clog2(MAX_OUTSTD + 1);
    localparam logic [c_OUT_WIDTH-1:0] c_OUT_MAX   = c_OUT_WIDTH'(MAX_OUTSTD);
    localparam logic [c_OUT_WIDTH-1:0] c_OUT_ONE   = c_OUT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE   = CNT_WIDTH'(1);

    localparam logic [3:0] c_OP_NOP     = 4'd0;
    localparam logic [3:0] c_OP_LOAD    = 4'd1;
    localparam logic [3:0] c_OP_COMPUTE = 4'd2;
    localparam logic [3:0] c_OP_STORE   = 4'd3;
    localparam logic [3:0] c_OP_SYNC    = 4'd4;

    localparam logic [1:0] c_ERR_NONE    = 2'd0;
    localparam logic [1:0] c_ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] c_ERR_ZLEN    = 2'd2;
    localparam logic [1:0] c_ERR_SPUR    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_SYNC_WAIT = 3'd3,
        ST_ERR       = 3'd4
    } state_t;

    state_t                   r_state;
    logic [WDATA_WIDTH-1:0]   r_cmd;
    logic [c_OUT_WIDTH-1:0]   r_outstd;
    logic [1:0]               r_err;
    logic [CNT_WIDTH-1:0]     r_cnt;

    logic                     w_ack;
    logic                     w_spur;
    logic                     w_done;
    logic [c_OUT_WIDTH-1:0]   w_outstd_nxt;
    logic [3:0]               w_opcode;
    logic                     w_len_zero;

    assign w_opcode   = r_cmd[31:28];
    assign w_len_zero = (r_cmd[27:16] == 12'd0);

    assign w_ack  = eng_req & eng_ack;
    // A done with nothing outstanding cannot belong to an op acked this cycle.
    assign w_spur = eng_done & (r_outstd == '0);
    assign w_done = eng_done & ~w_spur;

    always_comb begin
        w_outstd_nxt = r_outstd;
        if (w_ack && !w_done) begin
            w_outstd_nxt = r_outstd + c_OUT_ONE;
        end else if (!w_ack && w_done) begin
            w_outstd_nxt = r_outstd - c_OUT_ONE;
        end
    end

    assign ctrl_cmd_buff_rdy = rst_n & (r_state == ST_IDLE);
    assign eng_req           = (r_state == ST_ISSUE) & (r_outstd < c_OUT_MAX);
    assign eng_op            = r_cmd[29:28];
    assign eng_len           = r_cmd[27:16];
    assign eng_addr          = r_cmd[15:0];
    assign busy              = (r_state != ST_IDLE) | (r_outstd != '0);
    assign cmd_err           = r_err;
    assign cmd_cnt           = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cmd    <= '0;
            r_outstd <= '0;
            r_err    <= c_ERR_NONE;
            r_cnt    <= '0;
        end else begin
            r_outstd <= w_outstd_nxt;
            if (w_ack) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_spur) begin
                r_state <= ST_ERR;
                if (r_err == c_ERR_NONE || (r_state == ST_ERR && err_clr)) begin
                    r_err <= c_ERR_SPUR;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cmd_buff_ctrl_out_vld) begin
                            r_cmd   <= cmd_buff_ctrl_out_data;
                            r_state <= ST_DECODE;
                        end
                    end
                    ST_DECODE: begin
                        case (w_opcode)
                            c_OP_NOP: begin
                                r_cnt   <= r_cnt + c_CNT_ONE;
                                r_state <= ST_IDLE;
                            end
                            c_OP_LOAD, c_OP_STORE: begin
                                if (w_len_zero) begin
                                    if (r_err == c_ERR_NONE) r_err <= c_ERR_ZLEN;
                                    r_state <= ST_ERR;
                                end else begin
                                    r_state <= ST_ISSUE;
                                end
                            end
                            c_OP_COMPUTE: r_state <= ST_ISSUE;
                            c_OP_SYNC:    r_state <= ST_SYNC_WAIT;
                            default: begin
                                if (r_err == c_ERR_NONE) r_err <= c_ERR_ILLEGAL;
                                r_state <= ST_ERR;
                            end
                        endcase
                    end
                    ST_ISSUE: begin
                        if (w_ack) r_state <= ST_IDLE;
                    end
                    ST_SYNC_WAIT: begin
                        // Releases on the same edge as the done that drains the last op.
                        if (w_outstd_nxt == '0) begin
                            r_cnt   <= r_cnt + c_CNT_ONE;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_ERR: begin
                        if (err_clr) begin
                            r_err   <= c_ERR_NONE;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cmd_sched.sv
// ============================================================================
// Module : tb_cmd_sched
// Brief  : Scoreboard bench for cmd_sched with FIFO and engine models.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmd_sched;

    localparam int CW   = 4;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld = 1'b0;
    logic [31:0]   data = '0;
    logic          rdy;
    logic          eng_req;
    logic [1:0]    eng_op;
    logic [15:0]   eng_addr;
    logic [11:0]   eng_len;
    logic          eng_ack = 1'b0;
    logic          eng_done = 1'b0;
    logic          err_clr = 1'b0;
    logic          busy;
    logic [1:0]    cmd_err;
    logic [CW-1:0] cmd_cnt;

    cmd_sched #(.WDATA_WIDTH(32), .MAX_OUTSTD(MAXO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_buff_ctrl_out_vld(vld), .cmd_buff_ctrl_out_data(data),
        .ctrl_cmd_buff_rdy(rdy),
        .eng_req(eng_req), .eng_op(eng_op), .eng_addr(eng_addr), .eng_len(eng_len),
        .eng_ack(eng_ack), .eng_done(eng_done), .err_clr(err_clr),
        .busy(busy), .cmd_err(cmd_err), .cmd_cnt(cmd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] len;
        logic [15:0] addr;
        bit          after_sync;
    } exp_t;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    hs_total = 0;
    int    model_cnt = 0;
    bit    pend_sync = 0;
    exp_t  exp_q[$];
    logic [31:0] fifo_q[$];
    int    inflight_q[$];
    bit    pop_pending = 0;

    int ack_lat = 0;
    bit ack_rand = 0;
    bit auto_done = 0;
    int done_lo = 0, done_hi = 0;
    bit done_req = 0, spur_req = 0, done_with_ack = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event within budget, required event", name);
    endtask

    // Reference model: legal ops are expected in order; NOP/SYNC/issued ops retire.
    task automatic issue_cmd(input logic [31:0] w);
        exp_t e;
        fifo_q.push_back(w);
        case (w[31:28])
            4'd0: model_cnt++;
            4'd1, 4'd2, 4'd3: begin
                if (w[31:28] == 4'd2 || w[27:16] != 12'd0) begin
                    e.op = w[29:28]; e.len = w[27:16]; e.addr = w[15:0];
                    e.after_sync = pend_sync;
                    pend_sync = 0;
                    exp_q.push_back(e);
                    model_cnt++;
                end
            end
            4'd4: begin model_cnt++; pend_sync = 1; end
            default: ;
        endcase
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end
        while ((fifo_q.size() != 0 || vld || busy) && n < budget);
        if (fifo_q.size() != 0 || vld || busy) timeout(name);
        chk({name, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_err(input string name);
        int n;
        n = 0;
        while (cmd_err == 2'd0 && n < 20) begin @(negedge clk); n++; end
        if (cmd_err == 2'd0) timeout(name);
    endtask

    task automatic measure_latency(input string name);
        int n, t0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(vld && rdy) && n < 20);
        if (!(vld && rdy)) timeout({name, "_pop"});
        t0 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!eng_req && n < 20);
        chk(name, cyc - t0, 2);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Command FIFO: head presented on vld/data, popped on vld&rdy.
    initial forever begin
        @(negedge clk);
        pop_pending = rst_n && vld && rdy;
        @(posedge clk);
        #1;
        if (!rst_n) pop_pending = 0;
        if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
        vld  = (fifo_q.size() > 0);
        data = vld ? fifo_q[0] : 32'h0;
    end

    // Engine: acks requests, reports completions only for ops it holds.
    initial begin
        bit hs;
        int req_wait, idx;
        req_wait = 0;
        forever begin
            @(negedge clk);
            hs = rst_n && eng_req && eng_ack;
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (!rst_n) begin
                eng_ack  = 1'b0;
                req_wait = 0;
            end else begin
                foreach (inflight_q[i]) inflight_q[i]--;
                if (hs) begin
                    inflight_q.push_back(auto_done ? int'($urandom_range(done_hi, done_lo)) : 1000000);
                    req_wait = 0;
                end
                if (spur_req) begin
                    eng_done = 1'b1;
                    spur_req = 0;
                end else if (done_req && inflight_q.size() > 0) begin
                    inflight_q.delete(0);
                    eng_done = 1'b1;
                    done_req = 0;
                end else begin
                    idx = -1;
                    foreach (inflight_q[i]) if (idx < 0 && inflight_q[i] <= 0) idx = i;
                    if (idx >= 0) begin
                        inflight_q.delete(idx);
                        eng_done = 1'b1;
                    end
                end
                if (eng_req) begin
                    eng_ack = ack_rand ? ($urandom_range(0, 2) == 0) : (req_wait >= ack_lat);
                    req_wait++;
                    if (eng_ack && done_with_ack && !eng_done && inflight_q.size() > 0) begin
                        inflight_q.delete(0);
                        eng_done = 1'b1;
                    end
                end else begin
                    eng_ack  = 1'b0;
                    req_wait = 0;
                end
            end
        end
    end

    // Monitor: checks every engine handshake against the scoreboard.
    initial begin
        logic        pw;
        logic [29:0] pb;
        exp_t        e;
        int          occ;
        pw = 0;
        pb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pw = 0;
            end else begin
                if (pw) begin
                    chk("req_held", eng_req, 1);
                    chk("bus_stable", {eng_op, eng_len, eng_addr}, pb);
                end
                if (eng_req && eng_ack) begin
                    hs_total++;
                    occ = inflight_q.size() + (eng_done ? 1 : 0);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL issue_expected: got op=%0d addr=%0h with empty scoreboard, required no issue",
                                 eng_op, eng_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("issue_op", eng_op, e.op);
                        chk("issue_len", eng_len, e.len);
                        chk("issue_addr", eng_addr, e.addr);
                        if (e.after_sync) chk("sync_barrier", occ, 0);
                        chk("max_outstd", occ < MAXO, 1);
                    end
                end
                pw = eng_req && !eng_ack;
                pb = {eng_op, eng_len, eng_addr};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n, base;
        bit early;
        logic [31:0] w;
        logic [11:0] ln;
        logic [15:0] ad;
        int k;

        // Reset state
        cycles(3);
        chk("rst_rdy", rdy, 0);
        chk("rst_req", eng_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_cnt", cmd_cnt, 0);
        chk("rst_bus", {eng_op, eng_len, eng_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", rdy, 1);

        // Single LOAD, ack on the second request cycle
        ack_lat = 1;
        issue_cmd(32'h1004_0100);
        measure_latency("load_latency");
        n = 0;
        while (eng_req && n < 10) begin n++; @(negedge clk); end
        chk("load_req_cycles", n, 2);
        chk("load_cnt", cmd_cnt, model_cnt & 15);
        cycles(3);
        chk("load_busy_until_done", busy, 1);
        done_req = 1;
        cycles(3);
        chk("load_busy_after_done", busy, 0);

        // Outstanding limit: five COMPUTEs, no completions
        ack_lat = 0;
        base = hs_total;
        for (int i = 0; i < 5; i++) issue_cmd({4'h2, 12'(i), 16'(i * 16'h111)});
        issue_cmd(32'h0000_0000);
        cycles(25);
        chk("limit_issued", hs_total - base, 4);
        chk("limit_req_low", eng_req, 0);
        chk("limit_busy", busy, 1);
        chk("limit_no_pop", fifo_q.size(), 1);
        done_req = 1;
        n = 0;
        while (hs_total - base < 5 && n < 5) begin @(negedge clk); n++; end
        chk("limit_fifth_issued", hs_total - base, 5);
        n = 0;
        while (inflight_q.size() > 0 && n < 60) begin
            if (!done_req) done_req = 1;
            @(negedge clk);
            n++;
        end
        done_req = 0;
        wait_idle("limit_drain", 100);
        chk("limit_cnt", cmd_cnt, model_cnt & 15);

        // SYNC barrier
        auto_done = 1; done_lo = 10; done_hi = 10;
        issue_cmd(32'h1008_0200);
        issue_cmd(32'h3002_0300);
        issue_cmd(32'h4000_0000);
        issue_cmd(32'h0000_0000);
        n = 0;
        while (fifo_q.size() != 1 && n < 40) begin @(negedge clk); n++; end
        if (fifo_q.size() != 1) timeout("sync_reach");
        early = 0;
        n = 0;
        while (inflight_q.size() > 0 && n < 60) begin
            if (fifo_q.size() != 1) early = 1;
            @(negedge clk);
            n++;
        end
        chk("sync_nop_held", early, 0);
        wait_idle("sync_drain", 100);
        chk("sync_cnt", cmd_cnt, model_cnt & 15);

        // Illegal opcode blocks the FIFO until cleared
        done_lo = 3; done_hi = 3;
        issue_cmd(32'h7000_0000);
        issue_cmd(32'h1001_0040);
        wait_err("illegal_err");
        chk("illegal_code", cmd_err, 1);
        cycles(5);
        chk("illegal_rdy", rdy, 0);
        chk("illegal_no_pop", fifo_q.size(), 1);
        chk("illegal_busy", busy, 1);
        chk("illegal_req", eng_req, 0);
        pulse_clr();
        chk("illegal_cleared", cmd_err, 0);
        wait_idle("illegal_resume", 100);
        chk("illegal_cnt", cmd_cnt, model_cnt & 15);

        // Zero-length STORE
        issue_cmd(32'h3000_0010);
        wait_err("zlen_err");
        chk("zlen_code", cmd_err, 2);
        pulse_clr();
        chk("zlen_cleared", cmd_err, 0);
        wait_idle("zlen_idle", 50);

        // Spurious done while idle
        spur_req = 1;
        cycles(3);
        chk("spur_code", cmd_err, 3);
        chk("spur_rdy", rdy, 0);
        pulse_clr();
        chk("spur_cleared", cmd_err, 0);

        // Same-cycle ack and done with one op outstanding
        auto_done = 0;
        issue_cmd(32'h1002_0500);
        n = 0;
        while (inflight_q.size() != 1 && n < 20) begin @(negedge clk); n++; end
        if (inflight_q.size() != 1) timeout("ackdone_first");
        base = hs_total;
        done_with_ack = 1;
        issue_cmd(32'h2000_0600);
        n = 0;
        while (hs_total == base && n < 20) begin @(negedge clk); n++; end
        if (hs_total == base) timeout("ackdone_second");
        done_with_ack = 0;
        cycles(2);
        chk("ackdone_busy", busy, 1);
        done_req = 1;
        cycles(3);
        done_req = 0;
        chk("ackdone_drained", busy, 0);
        chk("ackdone_err", cmd_err, 0);
        chk("ackdone_cnt", cmd_cnt, model_cnt & 15);

        // Randomized legal traffic
        ack_rand = 1; auto_done = 1; done_lo = 0; done_hi = 8;
        for (int i = 0; i < 80; i++) begin
            k  = $urandom_range(0, 9);
            ln = 12'($urandom_range(1, 4095));
            ad = 16'($urandom);
            case (k)
                0:       w = {4'h0, ln, ad};
                1, 2:    w = {4'h1, ln, ad};
                3, 4:    w = {4'h3, ln, ad};
                5, 6, 7: w = {4'h2, ln, ad};
                8:       w = 32'h4000_0000;
                default: w = {4'h2, 12'h0, ad};
            endcase
            issue_cmd(w);
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 6));
        end
        wait_idle("rand_drain", 4000);
        chk("rand_cnt", cmd_cnt, model_cnt & 15);
        chk("rand_err", cmd_err, 0);

        // Asynchronous reset while a request is pending
        ack_rand = 0; ack_lat = 1000; auto_done = 0;
        issue_cmd(32'h1003_0700);
        n = 0;
        while (!eng_req && n < 20) begin @(negedge clk); n++; end
        if (!eng_req) timeout("rst_req_wait");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", eng_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", cmd_cnt, 0);
        chk("arst_err", cmd_err, 0);
        chk("arst_rdy", rdy, 0);
        fifo_q.delete();
        exp_q.delete();
        inflight_q.delete();
        model_cnt = 0;
        pend_sync = 0;
        vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_lat = 0; auto_done = 1; done_lo = 2; done_hi = 2;
        issue_cmd(32'h2005_0800);
        measure_latency("post_rst_latency");
        wait_idle("post_rst_drain", 50);
        chk("post_rst_cnt", cmd_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
